im_projm_sram_server: RTL and testbench

- Memory-side responder for one modality of the spatial encoder. It holds that modality's item memory (iM), negative projection matrix (projM_neg) and positive projection matrix (projM_pos), one HV_DIMENSION-bit row per channel.
- It answers the encoder's channel-address requests with the three rows and the bank valid/ready flags the encoder waits on.
- A host load port fills the three banks before serving starts.

---
 rtl/im_projm_sram_server_if.sv | 41 ++++
 rtl/im_projm_sram_server.sv | 159 +++++++++++++++
 tb/tb_im_projm_sram_server.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/im_projm_sram_server_if.sv
// Encoder request/response and host load bus for one modality's iM/projM server.
// The encoder and host side use the master modport. The server uses the slave modport.
interface im_projm_sram_server_if #(
   parameter int HV_DIMENSION = 2000,
   parameter int ADDR_WIDTH   = 8
);

   // Encoder-side fetch channel
   logic                    Req_SI;
   logic [ADDR_WIDTH-1:0]   Addr_DI;
   logic                    Ready_SO;
   logic                    Valid_SO;
   logic [HV_DIMENSION-1:0] IMOut_DO;
   logic [HV_DIMENSION-1:0] ProjNeg_DO;
   logic [HV_DIMENSION-1:0] ProjPos_DO;
   logic                    AddrErr_SO;

   // Host-side bank load channel
   logic                    LoadReq_SI;
   logic                    LoadValid_SI;
   logic                    LoadReady_SO;
   logic [1:0]              LoadSel_DI;
   logic [ADDR_WIDTH-1:0]   LoadAddr_DI;
   logic [HV_DIMENSION-1:0] LoadData_DI;
   logic                    LoadLast_SI;

   modport master (
      output Req_SI, Addr_DI,
      output LoadReq_SI, LoadValid_SI, LoadSel_DI, LoadAddr_DI, LoadData_DI, LoadLast_SI,
      input  Ready_SO, Valid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO, AddrErr_SO,
      input  LoadReady_SO
   );

   modport slave (
      input  Req_SI, Addr_DI,
      input  LoadReq_SI, LoadValid_SI, LoadSel_DI, LoadAddr_DI, LoadData_DI, LoadLast_SI,
      output Ready_SO, Valid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO, AddrErr_SO,
      output LoadReady_SO
   );

endinterface

// File: rtl/im_projm_sram_server.sv
// Memory-side responder for one modality of the spatial encoder.
// It holds the item memory and the negative/positive projection rows, and it answers
// channel-address requests with all three rows two cycles after it accepts a request.
// The host fills the banks through the load channel before serving starts.
module im_projm_sram_server #(
   parameter int HV_DIMENSION = 2000,
   parameter int ADDR_WIDTH   = 8,
   parameter int NUM_ROWS     = 214
) (
   input logic                    Clk_CI,
   input logic                    Reset_RI,
   im_projm_sram_server_if.slave  bus
);

   typedef enum logic [2:0] {
      UNLOADED,
      LOAD,
      SERVE_IDLE,
      FETCH,
      DATA_VALID
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   fetchAddr_q, fetchAddr_d;
   logic                    addrErr_q, addrErr_d;
   logic [HV_DIMENSION-1:0] imOut_q, imOut_d;
   logic [HV_DIMENSION-1:0] projNegOut_q, projNegOut_d;
   logic [HV_DIMENSION-1:0] projPosOut_q, projPosOut_d;

   // Bank storage has no reset. Contents survive a reset and are only changed by load beats.
   logic [HV_DIMENSION-1:0] imMem      [NUM_ROWS];
   logic [HV_DIMENSION-1:0] projNegMem [NUM_ROWS];
   logic [HV_DIMENSION-1:0] projPosMem [NUM_ROWS];

   logic                    acceptFetch;
   logic                    addrMatch;
   logic                    reqInRange;
   logic                    fetchInRange;
   logic                    loadInRange;
   logic                    loadWrite;
   logic [ADDR_WIDTH-1:0]   readIdx;

   assign addrMatch    = (bus.Addr_DI == fetchAddr_q);
   assign reqInRange   = (32'(bus.Addr_DI) < 32'(NUM_ROWS));
   assign fetchInRange = (32'(fetchAddr_q) < 32'(NUM_ROWS));
   assign loadInRange  = (32'(bus.LoadAddr_DI) < 32'(NUM_ROWS));

   // Out-of-range fetches read row 0 but return zeros, so the array index stays in bounds.
   assign readIdx = fetchInRange ? fetchAddr_q : '0;

   // Beats to bank select 3 or beyond the last row are accepted but dropped.
   assign loadWrite = (state_q == LOAD) && bus.LoadValid_SI && loadInRange &&
                      (bus.LoadSel_DI != 2'd3);

   // Status outputs are decoded from the state.
   // Valid follows the live address so that a moving encoder sees it drop at once.
   assign bus.Ready_SO     = (state_q == SERVE_IDLE) || (state_q == FETCH) ||
                             (state_q == DATA_VALID);
   assign bus.Valid_SO     = (state_q == DATA_VALID) && addrMatch;
   assign bus.LoadReady_SO = (state_q == LOAD);
   assign bus.AddrErr_SO   = addrErr_q;
   assign bus.IMOut_DO     = imOut_q;
   assign bus.ProjNeg_DO   = projNegOut_q;
   assign bus.ProjPos_DO   = projPosOut_q;

   // State register, latched fetch address, sticky error flag and the three output rows
   always_ff @(posedge Clk_CI or posedge Reset_RI) begin
      if (Reset_RI) begin
         state_q      <= UNLOADED;
         fetchAddr_q  <= '0;
         addrErr_q    <= 1'b0;
         imOut_q      <= '0;
         projNegOut_q <= '0;
         projPosOut_q <= '0;
      end else begin
         state_q      <= state_d;
         fetchAddr_q  <= fetchAddr_d;
         addrErr_q    <= addrErr_d;
         imOut_q      <= imOut_d;
         projNegOut_q <= projNegOut_d;
         projPosOut_q <= projPosOut_d;
      end
   end

   // Next-state logic. A fetch request beats a load request when both are pending.
   // A load request is only taken from SERVE_IDLE, or from DATA_VALID once the encoder has let go.
   always_comb begin
      state_d     = state_q;
      fetchAddr_d = fetchAddr_q;
      addrErr_d   = addrErr_q;
      acceptFetch = 1'b0;
      case (state_q)
         UNLOADED: begin
            if (bus.LoadReq_SI) state_d = LOAD;
         end
         LOAD: begin
            if (bus.LoadValid_SI && bus.LoadLast_SI) state_d = SERVE_IDLE;
         end
         SERVE_IDLE: begin
            if (bus.Req_SI) begin
               acceptFetch = 1'b1;
               state_d     = FETCH;
            end else if (bus.LoadReq_SI) begin
               state_d = LOAD;
            end
         end
         FETCH: begin
            state_d = DATA_VALID;
         end
         DATA_VALID: begin
            if (bus.Req_SI && !addrMatch) begin
               acceptFetch = 1'b1;
               state_d     = FETCH;
            end else if (!bus.Req_SI && bus.LoadReq_SI) begin
               state_d = LOAD;
            end
         end
         default: begin
            state_d = UNLOADED;
         end
      endcase
      if (acceptFetch) begin
         fetchAddr_d = bus.Addr_DI;
         addrErr_d   = addrErr_q | !reqInRange;
      end
   end

   // Output rows change only at the end of FETCH and are held otherwise.
   // An out-of-range address yields all-zero rows.
   always_comb begin
      imOut_d      = imOut_q;
      projNegOut_d = projNegOut_q;
      projPosOut_d = projPosOut_q;
      if (state_q == FETCH) begin
         if (fetchInRange) begin
            imOut_d      = imMem[readIdx];
            projNegOut_d = projNegMem[readIdx];
            projPosOut_d = projPosMem[readIdx];
         end else begin
            imOut_d      = '0;
            projNegOut_d = '0;
            projPosOut_d = '0;
         end
      end
   end

   // Write accepted load beats into the selected bank
   always_ff @(posedge Clk_CI) begin
      if (loadWrite) begin
         case (bus.LoadSel_DI)
            2'd0:    imMem[bus.LoadAddr_DI]      <= bus.LoadData_DI;
            2'd1:    projNegMem[bus.LoadAddr_DI] <= bus.LoadData_DI;
            2'd2:    projPosMem[bus.LoadAddr_DI] <= bus.LoadData_DI;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_im_projm_sram_server.sv
// Directed bench for im_projm_sram_server: load, fetch latency, sweep, hold,
// out-of-range, fetch/load priority and reset during a fetch.
module tb_im_projm_sram_server;

   localparam int HV   = 2000;
   localparam int AW   = 8;
   localparam int ROWS = 214;

   logic clock = 1'b0;
   logic reset;
   int   vectorCount = 0;
   int   missCount   = 0;
   int   validWindows;

   im_projm_sram_server_if #(.HV_DIMENSION(HV), .ADDR_WIDTH(AW)) bus ();

   im_projm_sram_server #(
      .HV_DIMENSION(HV),
      .ADDR_WIDTH  (AW),
      .NUM_ROWS    (ROWS)
   ) dut (
      .Clk_CI  (clock),
      .Reset_RI(reset),
      .bus     (bus)
   );

   // Free-running clock with a 10-unit period
   always #5 clock = ~clock;

   // Expected row for each bank: the row number's byte replicated across the hypervector.
   // projM_neg uses the inverted byte and projM_pos uses the byte XOR 0xA5.
   function automatic logic [HV-1:0] patRow(input int sel, input int r);
      logic [7:0]    b;
      logic [HV-1:0] v;
      b = 8'(r);
      if (sel == 1) b = ~b;
      if (sel == 2) b = b ^ 8'hA5;
      for (int i = 0; i < HV; i++) v[i] = b[i % 8];
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [HV-1:0] observed,
                              input logic [HV-1:0] expected);
      int firstBit;
      vectorCount++;
      if (observed !== expected) begin
         firstBit = -1;
         for (int i = HV - 1; i >= 0; i--) if (observed[i] !== expected[i]) firstBit = i;
         missCount++;
         $display("[TB] FAIL %s: observed %h, expected %h (low 64 bits; first differing bit %0d)",
                  tag, observed[63:0], expected[63:0], firstBit);
      end
   endtask

   task automatic checkRows(input string tag, input int r);
      checkOutput($sformatf("%s im[%0d]", tag, r),  bus.IMOut_DO,   patRow(0, r));
      checkOutput($sformatf("%s neg[%0d]", tag, r), bus.ProjNeg_DO, patRow(1, r));
      checkOutput($sformatf("%s pos[%0d]", tag, r), bus.ProjPos_DO, patRow(2, r));
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic applyStimulus(input logic req, input int addr);
      bus.Req_SI  = req;
      bus.Addr_DI = AW'(addr);
      #1;
   endtask

   task automatic loadBeat(input logic [1:0] sel, input int addr, input logic [HV-1:0] data,
                           input logic last);
      bus.LoadValid_SI = 1'b1;
      bus.LoadSel_DI   = sel;
      bus.LoadAddr_DI  = AW'(addr);
      bus.LoadData_DI  = data;
      bus.LoadLast_SI  = last;
      tick();
      bus.LoadValid_SI = 1'b0;
      bus.LoadLast_SI  = 1'b0;
   endtask

   // Bound the run in case the design wedges somewhere unexpected
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence
   initial begin
      reset            = 1'b1;
      bus.Req_SI       = 1'b0;
      bus.Addr_DI      = '0;
      bus.LoadReq_SI   = 1'b0;
      bus.LoadValid_SI = 1'b0;
      bus.LoadSel_DI   = '0;
      bus.LoadAddr_DI  = '0;
      bus.LoadData_DI  = '0;
      bus.LoadLast_SI  = 1'b0;
      repeat (2) tick();

      // Reset state
      checkOutput("rst ready",     HV'(bus.Ready_SO),     HV'(0));
      checkOutput("rst valid",     HV'(bus.Valid_SO),     HV'(0));
      checkOutput("rst loadReady", HV'(bus.LoadReady_SO), HV'(0));
      checkOutput("rst addrErr",   HV'(bus.AddrErr_SO),   HV'(0));
      checkOutput("rst im",        bus.IMOut_DO,          '0);
      reset = 1'b0;

      // A request while UNLOADED is ignored
      applyStimulus(1'b1, 3);
      tick();
      checkOutput("unloaded ready", HV'(bus.Ready_SO), HV'(0));
      checkOutput("unloaded valid", HV'(bus.Valid_SO), HV'(0));
      applyStimulus(1'b0, 0);

      // Fill all three banks
      bus.LoadReq_SI = 1'b1;
      tick();
      checkOutput("load loadReady", HV'(bus.LoadReady_SO), HV'(1));
      checkOutput("load ready",     HV'(bus.Ready_SO),     HV'(0));
      bus.LoadReq_SI = 1'b0;
      for (int s = 0; s < 3; s++) begin
         for (int r = 0; r < ROWS; r++) begin
            loadBeat(2'(s), r, patRow(s, r), (s == 2) && (r == ROWS - 1));
         end
      end
      checkOutput("served ready",     HV'(bus.Ready_SO),     HV'(1));
      checkOutput("served loadReady", HV'(bus.LoadReady_SO), HV'(0));
      checkOutput("served valid",     HV'(bus.Valid_SO),     HV'(0));

      // First fetch: address 5, valid two cycles after acceptance
      applyStimulus(1'b1, 5);
      checkOutput("fetch5 t valid", HV'(bus.Valid_SO), HV'(0));
      tick();
      checkOutput("fetch5 t+1 valid", HV'(bus.Valid_SO), HV'(0));
      checkOutput("fetch5 t+1 ready", HV'(bus.Ready_SO), HV'(1));
      tick();
      checkOutput("fetch5 t+2 valid", HV'(bus.Valid_SO), HV'(1));
      checkRows("fetch5", 5);

      // Encoder-style sweep over every row, two cycles per row
      validWindows = 0;
      for (int a = 0; a < ROWS; a++) begin
         applyStimulus(1'b1, a);
         checkOutput($sformatf("sweep %0d accept valid", a), HV'(bus.Valid_SO), HV'(0));
         tick();
         checkOutput($sformatf("sweep %0d fetch valid", a), HV'(bus.Valid_SO), HV'(0));
         tick();
         if (bus.Valid_SO === 1'b1) validWindows++;
         checkOutput($sformatf("sweep im[%0d]", a),  bus.IMOut_DO,   patRow(0, a));
         checkOutput($sformatf("sweep pos[%0d]", a), bus.ProjPos_DO, patRow(2, a));
      end
      checkOutput("sweep windows", HV'(validWindows),   HV'(ROWS));
      checkOutput("sweep addrErr", HV'(bus.AddrErr_SO), HV'(0));

      // Hold: request dropped with address 7 for ten cycles
      applyStimulus(1'b1, 7);
      tick();
      tick();
      applyStimulus(1'b0, 7);
      for (int c = 0; c < 10; c++) begin
         tick();
         checkOutput($sformatf("hold %0d valid", c), HV'(bus.Valid_SO), HV'(1));
         checkOutput($sformatf("hold %0d im", c),    bus.IMOut_DO,      patRow(0, 7));
      end
      applyStimulus(1'b0, 8);
      checkOutput("hold addr8 valid", HV'(bus.Valid_SO), HV'(0));
      tick();
      checkOutput("hold addr8 im", bus.IMOut_DO, patRow(0, 7));
      applyStimulus(1'b0, 7);
      checkOutput("hold back valid", HV'(bus.Valid_SO), HV'(1));

      // Out-of-range address returns zeros and sets the sticky error
      applyStimulus(1'b1, 220);
      tick();
      tick();
      checkOutput("oor valid",   HV'(bus.Valid_SO),   HV'(1));
      checkOutput("oor im",      bus.IMOut_DO,        '0);
      checkOutput("oor neg",     bus.ProjNeg_DO,      '0);
      checkOutput("oor pos",     bus.ProjPos_DO,      '0);
      checkOutput("oor addrErr", HV'(bus.AddrErr_SO), HV'(1));
      applyStimulus(1'b1, 9);
      tick();
      tick();
      checkRows("after oor", 9);
      checkOutput("sticky addrErr", HV'(bus.AddrErr_SO), HV'(1));

      // Back to LOAD, drop a bank-3 beat on row 9, return to SERVE_IDLE
      applyStimulus(1'b0, 9);
      bus.LoadReq_SI = 1'b1;
      tick();
      checkOutput("reload loadReady", HV'(bus.LoadReady_SO), HV'(1));
      checkOutput("reload ready",     HV'(bus.Ready_SO),     HV'(0));
      bus.LoadReq_SI = 1'b0;
      loadBeat(2'd3, 9, '1, 1'b1);
      checkOutput("reload done ready", HV'(bus.Ready_SO), HV'(1));

      // Request and load request together in SERVE_IDLE: the fetch wins
      bus.LoadReq_SI = 1'b1;
      applyStimulus(1'b1, 10);
      tick();
      checkOutput("prio fetch ready",     HV'(bus.Ready_SO),     HV'(1));
      checkOutput("prio fetch loadReady", HV'(bus.LoadReady_SO), HV'(0));
      tick();
      checkOutput("prio dv valid",     HV'(bus.Valid_SO),     HV'(1));
      checkOutput("prio dv loadReady", HV'(bus.LoadReady_SO), HV'(0));
      checkRows("prio", 10);
      tick();
      checkOutput("prio hold valid",     HV'(bus.Valid_SO),     HV'(1));
      checkOutput("prio hold loadReady", HV'(bus.LoadReady_SO), HV'(0));
      applyStimulus(1'b0, 10);
      tick();
      checkOutput("prio load loadReady", HV'(bus.LoadReady_SO), HV'(1));
      checkOutput("prio load ready",     HV'(bus.Ready_SO),     HV'(0));
      checkOutput("prio load valid",     HV'(bus.Valid_SO),     HV'(0));
      checkOutput("prio load im held",   bus.IMOut_DO,          patRow(0, 10));
      bus.LoadReq_SI = 1'b0;
      loadBeat(2'd3, 10, '1, 1'b1);

      // Rows 9 and 10 must be unchanged by the dropped beats
      applyStimulus(1'b1, 9);
      tick();
      tick();
      checkRows("sel3 row", 9);
      applyStimulus(1'b1, 10);
      tick();
      tick();
      checkRows("sel3 row", 10);

      // Reset in the middle of a fetch
      applyStimulus(1'b1, 11);
      tick();
      checkOutput("midfetch valid", HV'(bus.Valid_SO), HV'(0));
      reset = 1'b1;
      #1;
      checkOutput("async rst ready",     HV'(bus.Ready_SO),     HV'(0));
      checkOutput("async rst valid",     HV'(bus.Valid_SO),     HV'(0));
      checkOutput("async rst addrErr",   HV'(bus.AddrErr_SO),   HV'(0));
      checkOutput("async rst loadReady", HV'(bus.LoadReady_SO), HV'(0));
      checkOutput("async rst im",        bus.IMOut_DO,          '0);
      checkOutput("async rst neg",       bus.ProjNeg_DO,        '0);
      checkOutput("async rst pos",       bus.ProjPos_DO,        '0);
      tick();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput($sformatf("post rst %0d ready", c), HV'(bus.Ready_SO), HV'(0));
         checkOutput($sformatf("post rst %0d valid", c), HV'(bus.Valid_SO), HV'(0));
         checkOutput($sformatf("post rst %0d im", c),    bus.IMOut_DO,      '0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
